// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//
// Memory-side responder for the cache block interface. A request accepted in
// IDLE starts either a block refill (BLOCK_WORDS-word read burst delivered
// READ_LATENCY cycles after accept) or a block writeback (BLOCK_WORDS-word
// write burst captured one word per cycle starting at the accept edge).
// Every burst ends with a single DONE cycle that pulses mem_done.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset (the word array is not cleared)
//   mem_ren     block read request, sampled only in IDLE
//   mem_wen     block write request, sampled only in IDLE (wins over mem_ren)
//   mem_addr    byte address of the block; offset bits inside the block are
//               expected to be zero and are ignored (flagged on mem_err)
//   mem_din     write data, one word per cycle
//   mem_dout    registered read data, holds its value between bursts
//   mem_dvalid  mem_dout carries a burst word this cycle
//   mem_busy    burst in progress; requests are dropped
//   mem_done    one-cycle pulse in the DONE cycle
//   mem_err     sticky protocol error (read+write together, misaligned block)
//   dbg_addr    backdoor word index
//   dbg_dout    combinational backdoor read of the word array
// -----------------------------------------------------------------------------
module main_mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BLOCK_WORDS  = 32,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_ren,
    input  logic                         mem_wen,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_din,
    output logic [DATA_WIDTH-1:0]        mem_dout,
    output logic                         mem_dvalid,
    output logic                         mem_busy,
    output logic                         mem_done,
    output logic                         mem_err,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_dout
);

    // Word index = byte address >> 2, split into block number and beat.
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int BLK_W  = IDX_W - BEAT_W;
    localparam int OFF_W  = BEAT_W + 2;              // byte offset inside a block
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q,  beat_d;
    logic [LAT_W-1:0]     wait_q,  wait_d;
    logic [BLK_W-1:0]     blk_q,   blk_d;

    logic                 dvalid_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 err_d;

    // Array access controls produced by the next-state logic.
    logic                 rd_en;
    logic [IDX_W-1:0]     rd_idx;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] mem_array [MEM_WORDS];

    // Request decode. Address bits above the array depth alias modulo
    // MEM_WORDS, and the in-block offset is replaced by the beat counter so a
    // burst can never cross into the next block.
    logic [BLK_W-1:0] req_blk;
    logic             req_misaligned;
    logic             unused_addr_hi;

    assign req_blk        = mem_addr[OFF_W +: BLK_W];
    assign req_misaligned = |mem_addr[OFF_W-1:0];
    assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:IDX_W+2];

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        blk_d    = blk_q;
        busy_d   = mem_busy;
        err_d    = mem_err;
        dvalid_d = 1'b0;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        rd_idx   = {blk_q, beat_q};
        wr_en    = 1'b0;
        wr_idx   = {blk_q, beat_q};
        wr_data  = mem_din;

        unique case (state_q)
            IDLE: begin
                if (mem_ren || mem_wen) begin
                    blk_d  = req_blk;
                    busy_d = 1'b1;
                    wait_d = '0;
                    beat_d = '0;
                    if ((mem_ren && mem_wen) || req_misaligned) begin
                        err_d = 1'b1;
                    end
                    if (mem_wen) begin
                        // Word 0 is taken on the accept edge itself.
                        wr_en   = 1'b1;
                        wr_idx  = {req_blk, BEAT_W'(0)};
                        beat_d  = BEAT_W'(1);
                        state_d = WR_BURST;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // beat_q is still zero here, so the default rd_idx is word 0.
                if (wait_q == LAST_WAIT) begin
                    rd_en    = 1'b1;
                    dvalid_d = 1'b1;
                    beat_d   = BEAT_W'(1);
                    state_d  = RD_BURST;
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end

            RD_BURST: begin
                // The beat counter wraps to zero after the last word has been
                // issued; that wrap is the end-of-burst marker.
                if (beat_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    rd_en    = 1'b1;
                    dvalid_d = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                end
            end

            WR_BURST: begin
                wr_en  = 1'b1;
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // Requests seen here are deliberately not sampled.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset edge aborts the burst before it touches the array.
        if (rst) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wait_q     <= '0;
            blk_q      <= '0;
            mem_dout   <= '0;
            mem_dvalid <= 1'b0;
            mem_busy   <= 1'b0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            blk_q      <= blk_d;
            mem_dvalid <= dvalid_d;
            mem_busy   <= busy_d;
            mem_done   <= done_d;
            mem_err    <= err_d;
            if (rd_en) begin
                mem_dout <= mem_array[rd_idx];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Backing word array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch; clearing it would force a flop
    // implementation instead of a RAM, and contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_idx] <= wr_data;
        end
    end

    assign dbg_dout = mem_array[dbg_addr];

endmodule

// File: tb/tb_main_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_main_mem_responder
//
// Directed bench for main_mem_responder with default parameters. A table of
// block transactions (preload writes, reads, aliasing reads) is applied in a
// loop; hand-written sequences cover requests while busy, read+write
// collision, misaligned writes, and reset in the middle of a read burst.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_main_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int MW = 4096;
    localparam int RL = 4;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_dvalid;
    logic          mem_busy;
    logic          mem_done;
    logic          mem_err;
    logic [IW-1:0] dbg_addr;
    logic [DW-1:0] dbg_dout;

    int n_cmp = 0;
    int n_bad = 0;

    main_mem_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BLOCK_WORDS (BW),
        .MEM_WORDS   (MW),
        .READ_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_dvalid(mem_dvalid),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .dbg_addr  (dbg_addr),
        .dbg_dout  (dbg_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] base;   // word k of the block is base + k
        int          word;   // first array index the block maps to
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare array words [word, word+BW) against base + k via the backdoor.
    task automatic check_array(input string name, input int word, input logic [31:0] base);
        for (int k = 0; k < BW; k++) begin
            dbg_addr = IW'(word + k);
            #1;
            check(name, dbg_dout, base + 32'(k));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] base,
                            input bit both, input bit exp_err, input int word);
        @(negedge clk);
        mem_wen  = 1'b1;
        mem_ren  = both;
        mem_addr = addr;
        mem_din  = base;
        for (int k = 1; k < BW; k++) begin
            @(negedge clk);
            mem_wen = 1'b0;
            mem_ren = 1'b0;
            check("wr_busy", {31'd0, mem_busy}, 32'd1);
            mem_din = base + 32'(k);
        end
        @(negedge clk);
        check("wr_done", {31'd0, mem_done}, 32'd1);
        check("wr_done_busy", {31'd0, mem_busy}, 32'd0);
        check("wr_done_dvalid", {31'd0, mem_dvalid}, 32'd0);
        check("wr_err", {31'd0, mem_err}, {31'd0, exp_err});
        @(negedge clk);
        check("wr_done_drop", {31'd0, mem_done}, 32'd0);
        check_array("wr_array", word, base);
    endtask

    // poke: pulse mem_ren during the burst and during DONE (both must be dropped).
    // abort_at: if nonzero, assert rst right after that many dvalid cycles.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                           input bit exp_err, input bit poke, input int abort_at);
        int lat;
        int extra;
        @(negedge clk);
        mem_ren  = 1'b1;
        mem_addr = addr;
        @(negedge clk);
        mem_ren = 1'b0;
        check("rd_busy", {31'd0, mem_busy}, 32'd1);
        lat = 1;
        while (!mem_dvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(RL + 1));
        for (int k = 0; k < BW; k++) begin
            check("rd_dvalid", {31'd0, mem_dvalid}, 32'd1);
            check("rd_data", mem_dout, base + 32'(k));
            mem_ren = poke && (k == 5);
            if (abort_at == k + 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_dvalid", {31'd0, mem_dvalid}, 32'd0);
                check("abort_busy", {31'd0, mem_busy}, 32'd0);
                check("abort_done", {31'd0, mem_done}, 32'd0);
                return;
            end
            @(negedge clk);
        end
        check("rd_done", {31'd0, mem_done}, 32'd1);
        check("rd_done_dvalid", {31'd0, mem_dvalid}, 32'd0);
        check("rd_done_busy", {31'd0, mem_busy}, 32'd0);
        check("rd_err", {31'd0, mem_err}, {31'd0, exp_err});
        mem_ren = poke;
        @(negedge clk);
        mem_ren = 1'b0;
        check("rd_done_drop", {31'd0, mem_done}, 32'd0);
        check("rd_no_resample", {31'd0, mem_busy}, 32'd0);
        if (poke) begin
            extra = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (mem_dvalid || mem_busy) extra++;
            end
            check("busy_req_ignored", 32'(extra), 32'd0);
            check("busy_req_no_err", {31'd0, mem_err}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{is_wr: 1'b1, addr: 32'h0000_0000, base: 32'hA500_0000, word: 0};
        vecs[1] = '{is_wr: 1'b1, addr: 32'h0000_0080, base: 32'hA500_0020, word: 32};
        vecs[2] = '{is_wr: 1'b0, addr: 32'h0000_0080, base: 32'hA500_0020, word: 32};
        vecs[3] = '{is_wr: 1'b1, addr: 32'h0000_0100, base: 32'hC0DE_0000, word: 64};
        vecs[4] = '{is_wr: 1'b0, addr: 32'h0000_0100, base: 32'hC0DE_0000, word: 64};
        vecs[5] = '{is_wr: 1'b0, addr: 32'h0000_4000, base: 32'hA500_0000, word: 0};
        vecs[6] = '{is_wr: 1'b0, addr: 32'h0000_4080, base: 32'hA500_0020, word: 32};

        rst      = 1'b1;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", mem_dout, 32'd0);
        check("reset_dvalid", {31'd0, mem_dvalid}, 32'd0);
        check("reset_busy", {31'd0, mem_busy}, 32'd0);
        check("reset_done", {31'd0, mem_done}, 32'd0);
        check("reset_err", {31'd0, mem_err}, 32'd0);
        rst = 1'b0;

        // Table-driven block transactions, all protocol-clean.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].base, 1'b0, 1'b0, vecs[i].word);
            end else begin
                do_read(vecs[i].addr, vecs[i].base, 1'b0, 1'b0, 0);
            end
        end

        // Requests while busy and during DONE are dropped without error.
        do_read(32'h0000_0080, 32'hA500_0020, 1'b0, 1'b1, 0);

        // Read and write together: write wins, error sticks until reset.
        do_write(32'h0000_0180, 32'h5EED_0000, 1'b1, 1'b1, 96);
        do_read(32'h0000_0180, 32'h5EED_0000, 1'b1, 1'b0, 0);
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        pulse_reset();

        // Misaligned write is served block-aligned and flags an error.
        do_write(32'h0000_0104, 32'h7777_0000, 1'b0, 1'b1, 64);
        pulse_reset();

        // Reset after the 10th word of a read, then a clean re-read.
        do_read(32'h0000_0100, 32'h7777_0000, 1'b0, 1'b0, 10);
        check_array("abort_array", 64, 32'h7777_0000);
        do_read(32'h0000_0100, 32'h7777_0000, 1'b0, 1'b0, 0);
        check_array("block0_intact", 0, 32'hA500_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
